fp_arith_seq: RTL and testbench

FP_ARITH_SEQ -- requirements
Module: fp_arith_seq

---
 rtl/fp_arith_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_arith_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_arith_seq.sv
// Multi-cycle floating-point add/sub/mult with round-to-nearest-even and flush-to-zero.
// One operation in flight, fixed ALIGN/COMPUTE/NORM/ROUND sequence, result held until taken.
module fp_arith_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] numA,
  input  logic [EXP_W+FRAC_W:0] numB,
  input  logic [1:0]            operation,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic [3:0]            flags
);

  // state     | meaning
  // S_IDLE    | waiting for an operation, in_ready high
  // S_ALIGN   | decode specials, pick larger operand, align smaller one
  // S_COMPUTE | add/subtract magnitudes or multiply significands
  // S_NORM    | single-step normalisation by carry or leading-zero count
  // S_ROUND   | RNE rounding, overflow/underflow, result capture
  // S_DONE    | result presented, waiting for out_ready
  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_COMPUTE, S_NORM, S_ROUND, S_DONE
  } state_t;

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int SW = FRAC_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [SW-1:0] SW_ONE = SW'(1);
  localparam logic [1:0]    OP_SUB = 2'b01;
  localparam logic [1:0]    OP_MUL = 2'b10;

  state_t state, state_nxt;

  logic [W-1:0]            a_r, b_r;
  logic [1:0]              op_r;
  logic [SW-1:0]           big_r, sml_r, nrm_r;
  logic [SW:0]             sum_r;
  logic signed [EW-1:0]    exp_r;
  logic                    sign_r, eff_sub_r, mul_r, zero_r;
  logic                    spec_r;
  logic [W-1:0]            spec_res_r, result_r;
  logic [3:0]              spec_flg_r, flags_r;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (in_valid) state_nxt = S_ALIGN;
      S_ALIGN:   state_nxt = S_COMPUTE;
      S_COMPUTE: state_nxt = S_NORM;
      S_NORM:    state_nxt = S_ROUND;
      S_ROUND:   state_nxt = S_DONE;
      S_DONE:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  logic [EXP_W-1:0]     ea, eb, big_e, sml_e;
  logic [FRAC_W-1:0]    fa, fb;
  logic [W-2:0]         a_mag, b_mag;
  logic                 sa, sb, is_mul, a_big;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [SW-1:0]        siga, sigb, sml, sml_sh, mask;
  logic [31:0]          dsh;
  logic signed [EW-1:0] al_exp;
  logic                 al_spec;
  logic [W-1:0]         al_sres;
  logic [3:0]           al_sflg;

  always_comb begin
    ea     = a_r[W-2:FRAC_W];
    eb     = b_r[W-2:FRAC_W];
    fa     = a_r[FRAC_W-1:0];
    fb     = b_r[FRAC_W-1:0];
    sa     = a_r[W-1];
    sb     = b_r[W-1] ^ (op_r == OP_SUB);
    is_mul = (op_r == OP_MUL);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    // subnormal inputs have exponent zero and are treated as zero here
    siga   = a_zero ? '0 : {1'b1, fa, 3'b000};
    sigb   = b_zero ? '0 : {1'b1, fb, 3'b000};
    a_mag  = a_zero ? '0 : a_r[W-2:0];
    b_mag  = b_zero ? '0 : b_r[W-2:0];
    a_big  = (a_mag >= b_mag);
    big_e  = a_big ? ea : eb;
    sml_e  = a_big ? eb : ea;
    sml    = a_big ? sigb : siga;
    dsh    = {{(32-EXP_W){1'b0}}, big_e - sml_e};
    mask   = (SW_ONE << dsh) - SW_ONE;
    if (dsh >= FRAC_W + 3) sml_sh = {{(SW-1){1'b0}}, |sml};
    else                   sml_sh = (sml >> dsh) | {{(SW-1){1'b0}}, |(sml & mask)};
    if (is_mul) al_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    else        al_exp = $signed({2'b00, big_e});

    al_spec = 1'b0;
    al_sres = '0;
    al_sflg = '0;
    if (op_r == 2'b11 || a_nan || b_nan) begin
      al_spec = 1'b1; al_sres = QNAN; al_sflg = 4'b1000;
    end else if (!is_mul) begin
      if (a_inf && b_inf && (sa != sb)) begin
        al_spec = 1'b1; al_sres = QNAN; al_sflg = 4'b1000;
      end else if (a_inf) begin
        al_spec = 1'b1; al_sres = {sa, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (b_inf) begin
        al_spec = 1'b1; al_sres = {sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (a_zero && b_zero) begin
        al_spec = 1'b1; al_sres = {sa & sb, {(W-1){1'b0}}};
      end
    end else begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        al_spec = 1'b1; al_sres = QNAN; al_sflg = 4'b1000;
      end else if (a_inf || b_inf) begin
        al_spec = 1'b1; al_sres = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        al_spec = 1'b1; al_sres = {sa ^ sb, {(W-1){1'b0}}};
      end
    end
  end

  logic [2*MW-1:0] prod;
  logic [SW:0]     cp_sum;

  always_comb begin
    prod = {{MW{1'b0}}, big_r[SW-1:3]} * {{MW{1'b0}}, sml_r[SW-1:3]};
    if (mul_r) begin
      // map the 1.x product point onto the add-path hidden-bit position
      cp_sum    = prod[2*MW-1:MW-4];
      cp_sum[0] = prod[MW-4] | (|prod[MW-5:0]);
    end else if (eff_sub_r) begin
      cp_sum = {1'b0, big_r} - {1'b0, sml_r};
    end else begin
      cp_sum = {1'b0, big_r} + {1'b0, sml_r};
    end
  end

  logic signed [EW-1:0] lz, ne;
  logic [SW-1:0]        nm;
  logic                 nz;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++)
      if (sum_r[i]) lz = EW'(SW - 1 - i);
    nz = (sum_r == '0);
    if (sum_r[SW]) begin
      nm    = sum_r[SW:1];
      nm[0] = sum_r[1] | sum_r[0];
      ne    = exp_r + EW'(1);
    end else begin
      nm = sum_r[SW-1:0] << lz;
      ne = exp_r - lz;
    end
  end

  logic                 g, r, s, up, inx;
  logic [MW:0]          mant;
  logic signed [EW-1:0] rnd_e;
  logic [FRAC_W-1:0]    rnd_f;
  logic [W-1:0]         rd_res;
  logic [3:0]           rd_flg;

  always_comb begin
    g     = nrm_r[2];
    r     = nrm_r[1];
    s     = nrm_r[0];
    inx   = g | r | s;
    up    = g & (r | s | nrm_r[3]);
    mant  = {1'b0, nrm_r[SW-1:3]} + {{MW{1'b0}}, up};
    rnd_e = mant[MW] ? exp_r + EW'(1) : exp_r;
    rnd_f = mant[MW] ? mant[MW-1:1] : mant[MW-2:0];
    if (spec_r) begin
      rd_res = spec_res_r;
      rd_flg = spec_flg_r;
    end else if (zero_r) begin
      rd_res = '0;
      rd_flg = {3'b000, inx};
    end else if (rnd_e >= EMAX) begin
      rd_res = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rd_flg = 4'b0101;
    end else if (rnd_e[EW-1] || rnd_e == '0) begin
      rd_res = {sign_r, {(W-1){1'b0}}};
      rd_flg = 4'b0011;
    end else begin
      rd_res = {sign_r, rnd_e[EXP_W-1:0], rnd_f};
      rd_flg = {3'b000, inx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= '0;
      flags_r  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_r  <= numA;
          b_r  <= numB;
          op_r <= operation;
        end
        S_ALIGN: begin
          big_r      <= (is_mul || a_big) ? siga : sigb;
          sml_r      <= is_mul ? sigb : sml_sh;
          sign_r     <= is_mul ? (sa ^ sb) : (a_big ? sa : sb);
          eff_sub_r  <= !is_mul && (sa != sb);
          mul_r      <= is_mul;
          exp_r      <= al_exp;
          spec_r     <= al_spec;
          spec_res_r <= al_sres;
          spec_flg_r <= al_sflg;
        end
        S_COMPUTE: sum_r <= cp_sum;
        S_NORM: begin
          nrm_r  <= nm;
          exp_r  <= ne;
          zero_r <= nz;
        end
        S_ROUND: begin
          result_r <= rd_res;
          flags_r  <= rd_flg;
        end
        default: ;
      endcase
    end
  end

  assign result = result_r;
  assign flags  = flags_r;

endmodule

// File: tb/tb_fp_arith_seq.sv
// Scoreboard bench for fp_arith_seq (binary32): directed vectors with hand-computed results,
// back-pressure hold, accept-after-handshake timing and reset abort.
module tb_fp_arith_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] numA = '0, numB = '0;
  logic [1:0]  operation = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_arith_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .numA(numA), .numB(numB), .operation(operation), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int          tests = 0;
  int          fails = 0;
  bit          busy = 1'b0;
  int          hs_cyc = 0;
  logic [31:0] held_res;
  logic [3:0]  held_flg;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // called just after a rising edge; returns just after the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] r, input logic [3:0] f, input bit push,
                       output int acc);
    int   n;
    exp_t e;
    numA = a; numB = b; operation = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    acc = cyc;
    if (push) begin
      e.res = r; e.flg = f; e.acc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    numA      = $urandom;
    numB      = $urandom;
    operation = 2'($urandom_range(3, 0));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0 || busy) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
      end else if (out_valid) begin
        if (!busy) begin
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out: got result 0x%0h, expected no output", result);
          end else begin
            e = sb_q.pop_front();
            chk("result", result, e.res);
            chk("flags", 32'(flags), 32'(e.flg));
            chk("latency", 32'(cyc - e.acc), 32'd5);
          end
          held_res = result;
          held_flg = flags;
          busy = 1'b1;
        end else begin
          chk("hold_result", result, held_res);
          chk("hold_flags", 32'(flags), 32'(held_flg));
        end
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          busy   = 1'b0;
          hs_cyc = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acc, acc2, n;
    vecs.push_back('{32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 4'h0});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 4'h0});
    vecs.push_back('{32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, 4'h1});
    vecs.push_back('{32'h40400000, 32'hC0000000, 2'b10, 32'hC0C00000, 4'h0});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 4'h5});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 4'h8});
    vecs.push_back('{32'h3F800000, 32'h40000000, 2'b11, 32'h7FC00000, 4'h8});
    vecs.push_back('{32'h3F800000, 32'h33800001, 2'b00, 32'h3F800001, 4'h1});
    vecs.push_back('{32'h3F800001, 32'h33800000, 2'b00, 32'h3F800002, 4'h1});
    vecs.push_back('{32'h3FFFFFFF, 32'h33800000, 2'b00, 32'h40000000, 4'h1});
    vecs.push_back('{32'h00800000, 32'h00800000, 2'b10, 32'h00000000, 4'h3});
    vecs.push_back('{32'h7F800000, 32'h00000000, 2'b10, 32'h7FC00000, 4'h8});
    vecs.push_back('{32'h40000000, 32'h3F800000, 2'b01, 32'h3F800000, 4'h0});
    vecs.push_back('{32'h3F800000, 32'h40000000, 2'b01, 32'hBF800000, 4'h0});
    vecs.push_back('{32'h00000001, 32'h3F800000, 2'b00, 32'h3F800000, 4'h0});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'h8});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 2'b10, 32'hFF800000, 4'h0});
    vecs.push_back('{32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 4'h5});
    vecs.push_back('{32'h80000000, 32'h80000000, 2'b00, 32'h80000000, 4'h0});
    vecs.push_back('{32'h3FC00000, 32'h3FC00000, 2'b10, 32'h40100000, 4'h0});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800002, 4'h1});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000, 4'h8});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 4'h0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f, 1'b1, acc);
    drain();

    // back-pressure: hold the result three cycles, offer the next op meanwhile
    out_ready = 1'b0;
    issue(32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 4'h0, 1'b1, acc);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: out_valid stayed 0, expected 1");
    end
    @(posedge clk); #1;
    fork
      issue(32'h40400000, 32'hC0000000, 2'b10, 32'hC0C00000, 4'h0, 1'b1, acc2);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("accept_after_handshake", 32'(acc2 - hs_cyc), 32'd1);
    drain();

    // leave non-zero result/flags, then abort an op in COMPUTE
    issue(32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, 4'h1, 1'b1, acc);
    drain();
    issue(32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 4'h0, 1'b0, acc);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    issue(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 4'h0, 1'b1, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
